// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one Kogge-Stone adder among NREQ requesters.
// The result lands in a single-entry response register tagged with the requester id.
module adder_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout
);

    // Parallel-prefix adder; the carry-in is folded into bit 0's generate term.
    function automatic logic [W:0] ks_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
        logic [W-1:0] p0;
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] gn;
        logic [W-1:0] pn;
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        g[0] = g[0] | (p0[0] & cin);
        for (int d = 1; d < W; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = 0; i < W; i++) begin
                if (i >= d) begin
                    gn[i] = g[i] | (p[i] & g[i-d]);
                    pn[i] = p[i] & p[i-d];
                end else begin
                    gn[i] = g[i];
                    pn[i] = p[i];
                end
            end
            g = gn;
            p = pn;
        end
        return {g[W-1], p0 ^ {g[W-2:0], cin}};
    endfunction

    logic [IDW-1:0] rr_ptr_r;
    logic [IDW-1:0] gnt_id_s;
    logic           found_s;
    logic [IDW:0]   idx_s;
    logic           can_accept_s;
    logic           transfer_s;
    logic [W-1:0]   a_mux_s;
    logic [W-1:0]   b_mux_s;
    logic           cin_mux_s;
    logic [W:0]     add_s;

    assign can_accept_s = ~rsp_valid | rsp_ready;

    // Scan requesters starting at rr_ptr, wrapping, and pick the first valid one.
    always_comb begin
        found_s  = 1'b0;
        gnt_id_s = {IDW{1'b0}};
        idx_s    = {(IDW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (idx_s >= (IDW+1)'(NREQ)) begin
                idx_s = idx_s - (IDW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[IDW-1:0]]) begin
                found_s  = 1'b1;
                gnt_id_s = idx_s[IDW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // One-hot grant, suppressed under backpressure and while reset is held.
    always_comb begin
        if (found_s && can_accept_s && rst_n) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    assign transfer_s = |req_ready;

    // AND-OR operand mux feeding the shared adder.
    always_comb begin
        a_mux_s   = {W{1'b0}};
        b_mux_s   = {W{1'b0}};
        cin_mux_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_mux_s   = a_mux_s | (req_a[i*W +: W] & {W{gnt_id_s == IDW'(i)}});
            b_mux_s   = b_mux_s | (req_b[i*W +: W] & {W{gnt_id_s == IDW'(i)}});
            cin_mux_s = cin_mux_s | (req_cin[i] & (gnt_id_s == IDW'(i)));
        end
    end

    assign add_s = ks_add(a_mux_s, b_mux_s, cin_mux_s);

    // Response register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= {IDW{1'b0}};
            rsp_sum   <= {W{1'b0}};
            rsp_cout  <= 1'b0;
            rr_ptr_r  <= {IDW{1'b0}};
        end else if (transfer_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id_s;
            rsp_sum   <= add_s[W-1:0];
            rsp_cout  <= add_s[W];
            rr_ptr_r  <= (gnt_id_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : gnt_id_s + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

endmodule
